seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
//
// PURPOSE
// Serial bit-stream transmitter: the driving end of the serial din link into
// seq_detector_mealy. It accepts a parallel pattern word via a valid/ready
// handshake and shifts the active bits out MSB-first, one bit per clk. The
// pass repeats a programmable number of times with an optional idle gap.
// Used on-chip as a built-in stimulus source and loopback driver for the detector.
//
// PARAMETERS
// WIDTH   16  maximum pattern length in bits
// LEN_W   5   width of len input; must satisfy 2**LEN_W > WIDTH
// REP_W   4   width of reps input (number of passes = reps+1)
// GAP_W   4   width of gap input (idle cycles between passes)
//
// PORTS
// clk         in   1      system clock, rising edge
// reset       in   1      asynchronous, active-high reset
// load_valid  in   1      request to start a transmission
// load_ready  out  1      high when a request can be accepted (state IDLE)
// pattern     in   WIDTH  bits to send; active field is pattern[len-1:0]
// len         in   LEN_W  active bit count; 0 = no-op, >WIDTH clamps to WIDTH
// reps        in   REP_W  extra passes after the first
// gap         in   GAP_W  idle cycles inserted between passes
// dout        out  1      serial data; connects to detector din
// dout_valid  out  1      high while dout carries a pattern bit
// busy        out  1      high in SHIFT or GAP
// done        out  1      one-cycle pulse after the final bit of the final pass
//
// BEHAVIOUR
// - One clock, asynchronous active-high reset. All outputs are registered.
// - Reset values: dout=0, dout_valid=0, load_ready=1, busy=0, done=0, state=IDLE.
// - FSM states:
//   - IDLE: load_ready=1.
//   - SHIFT: emits one bit per cycle. bit_idx counts down len-1..0.
//   - GAP: dout=0, dout_valid=0. gap_cnt counts down gap..1.
// - Accept occurs at the edge where load_valid&&load_ready is sampled high.
//   pattern, len (clamped), reps and gap are captured into internal registers.
//   Later changes on these inputs have no effect.
// - Latency: the first bit is pattern[len-1], valid in the cycle right after the accept edge.
//   Bits follow MSB-first with no bubbles inside a pass.
// - End of pass, with passes remaining:
//   - gap!=0: SHIFT->GAP for exactly gap cycles, then SHIFT restarts at bit len-1.
//   - gap==0: the next pass starts in the next cycle, with no bubble.
// - End of final pass: at that edge, dout_valid<=0, dout<=0, done<=1, busy<=0, load_ready<=1.
//   State returns to IDLE. done lasts exactly 1 cycle.
// - load_valid in the done cycle is accepted; back-to-back transfers leave a
//   minimum one-cycle hole in dout_valid.
// - len==0 accept: no bits are sent, state stays IDLE, done pulses on the next cycle.
// - len>WIDTH: treated as len=WIDTH.
// - load_valid while busy: ignored (load_ready=0); nothing is queued.
// - reps at maximum (2**REP_W-1) gives 2**REP_W passes, with no counter overflow.
// - Reset asserted mid-transfer: outputs go to reset values immediately and
//   the partial pattern is discarded. Operation resumes cleanly after deassertion.
//
// STRUCTURE
// - Shared include/package seq_pkg:
//   - state encodings ST_IDLE, ST_SHIFT, ST_GAP;
//   - DETECT_PATTERN=5'b11010 and DETECT_LEN=5, shared with seq_detector_mealy.
// - One sub-module, seq_down_counter: loadable down-counter with a zero flag.
//   It is instantiated for bit_idx, gap_cnt and rep_cnt.
// - Top level contains the FSM, capture registers and output registers.
//
// TESTING
// - Reset: hold reset 2 cycles -> dout=0, dout_valid=0, load_ready=1, done=0.
//   Deassert reset, then load pattern=16'h001A, len=5, reps=0, gap=0:
//   - dout emits 1,1,0,1,0 on 5 consecutive cycles;
//   - done pulses on cycle 6;
//   - the seq_detector_mealy attached to dout asserts dout on the 5th bit.
// - Repeat with gap: pattern=16'h0005, len=3, reps=2, gap=2:
//   - stream is 101,--,101,--,101, where "-" means dout_valid=0;
//   - busy stays high for 13 cycles, then done pulses.
// - Boundaries:
//   - len=0: no dout_valid, done pulses 1 cycle after accept.
//   - len=31: clamps to 16 bits.
//   - reps=15, gap=0: 16 back-to-back passes with no bubble.
// - Handshake: toggle load_valid and pattern during SHIFT -> ignored, and the
//   stream is unchanged. A load in the done cycle is accepted, and its first
//   bit appears on the next cycle.
// - Reset mid-stream: assert reset after the 2nd of 5 bits ->
//   dout_valid=0 with no done pulse. A fresh load after release transmits the full pattern.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the Mealy detector it drives.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_t;

    // Sequence recognised by seq_detector_mealy; the generator is its loopback source.
    localparam logic [4:0] DETECT_PATTERN = 5'b11010;
    localparam int         DETECT_LEN     = 5;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that holds at zero; load wins over decrement.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: captures a word on a valid/ready handshake and shifts
// its active bits out MSB-first, repeating reps+1 times with an optional idle gap.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    seq_state_t state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic dout_q, dout_d;
    logic dout_valid_q, dout_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic load_ready_q, load_ready_d;

    logic             accept;
    logic [LEN_W-1:0] len_c;
    logic             first_bit;
    logic             restart_bit;
    logic             next_bit;

    logic             bit_load, bit_dec, bit_zero;
    logic [LEN_W-1:0] bit_load_val, bit_cnt;
    logic             rep_load, rep_dec, rep_zero;
    logic [REP_W-1:0] rep_cnt_unused;
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_load_val, gap_cnt_unused;

    assign accept = load_valid && load_ready_q;
    assign len_c  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

    // bit_cnt always holds the index of the bit currently on dout.
    assign first_bit    = |(pattern & (ONE << (len_c - LEN_W'(1))));
    assign restart_bit  = |(pat_q & (ONE << (len_q - LEN_W'(1))));
    assign next_bit     = |(pat_q & (ONE << (bit_cnt - LEN_W'(1))));
    assign gap_load_val = gap_q - GAP_W'(1);

    seq_down_counter #(.W(LEN_W)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bit_load),
        .load_val (bit_load_val),
        .dec      (bit_dec),
        .count    (bit_cnt),
        .zero     (bit_zero)
    );

    seq_down_counter #(.W(REP_W)) u_rep_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (rep_load),
        .load_val (reps),
        .dec      (rep_dec),
        .count    (rep_cnt_unused),
        .zero     (rep_zero)
    );

    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (gap_load_val),
        .dec      (gap_dec),
        .count    (gap_cnt_unused),
        .zero     (gap_zero)
    );

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        gap_d        = gap_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        load_ready_d = 1'b0;
        bit_load     = 1'b0;
        bit_load_val = len_q - LEN_W'(1);
        bit_dec      = 1'b0;
        rep_load     = 1'b0;
        rep_dec      = 1'b0;
        gap_load     = 1'b0;
        gap_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready_d = 1'b1;
                if (accept) begin
                    pat_d    = pattern;
                    len_d    = len_c;
                    gap_d    = gap;
                    rep_load = 1'b1;
                    if (len_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = ST_SHIFT;
                        bit_load     = 1'b1;
                        bit_load_val = len_c - LEN_W'(1);
                        dout_d       = first_bit;
                        dout_valid_d = 1'b1;
                        busy_d       = 1'b1;
                        load_ready_d = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                if (!bit_zero) begin
                    bit_dec      = 1'b1;
                    dout_d       = next_bit;
                    dout_valid_d = 1'b1;
                end else if (!rep_zero) begin
                    rep_dec = 1'b1;
                    if (gap_q != '0) begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                    end else begin
                        bit_load     = 1'b1;
                        dout_d       = restart_bit;
                        dout_valid_d = 1'b1;
                    end
                end else begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    load_ready_d = 1'b1;
                end
            end
            ST_GAP: begin
                // Gap counter is loaded with gap-1 so that zero marks the last idle cycle.
                busy_d = 1'b1;
                if (gap_zero) begin
                    state_d      = ST_SHIFT;
                    bit_load     = 1'b1;
                    dout_d       = restart_bit;
                    dout_valid_d = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                load_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: streams are logged as '1'/'0'/'-' per cycle
// and compared against hand-derived strings.
module tb_seq_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic [3:0]  gap;
    logic        dout;
    logic        dout_valid;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    seq_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .gap        (gap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accepts one request, then logs each cycle until done (cycle index of done
    // counted from the accept edge). Inputs are scrambled after accept.
    task automatic run_xfer(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r,
                            input logic [3:0] g, input bit toggle, output string s,
                            output int done_at, output int busy_cnt, output int ready_cnt);
        s = "";
        done_at = -1;
        busy_cnt = 0;
        ready_cnt = 0;
        load_valid = 1'b1;
        pattern = p;
        len = l;
        reps = r;
        gap = g;
        tick();
        load_valid = 1'b0;
        pattern = 16'($urandom);
        len = 5'($urandom);
        reps = 4'($urandom);
        gap = 4'($urandom);
        for (int k = 1; k <= 200; k++) begin
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            if (dout_valid === 1'b1) s = {s, (dout === 1'b1) ? "1" : "0"};
            else s = {s, "-"};
            if (busy === 1'b1) busy_cnt++;
            if (load_ready === 1'b1) ready_cnt++;
            if (toggle) begin
                load_valid = k[0];
                pattern = 16'($urandom);
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load_valid = 1'b0;
        pattern = '0;
        len = '0;
        reps = '0;
        gap = '0;
        tick();
        tick();
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        string s;
        int d, b, rd;
        run_xfer(16'h001A, 5'd5, 4'd0, 4'd0, 1'b0, s, d, b, rd);
        checks++; if (s != "11010") begin errors++; $display("FAIL basic_stream: got %s expected 11010", s); end
        checks++; if (d !== 6) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 6", d); end
        checks++; if (b !== 5) begin errors++; $display("FAIL basic_busy: got %0d expected 5", b); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
    endtask

    task automatic test_gap;
        string s;
        int d, b, rd;
        run_xfer(16'h0005, 5'd3, 4'd2, 4'd2, 1'b0, s, d, b, rd);
        checks++; if (s != "101--101--101") begin errors++; $display("FAIL gap_stream: got %s expected 101--101--101", s); end
        checks++; if (b !== 13) begin errors++; $display("FAIL gap_busy: got %0d expected 13", b); end
        checks++; if (d !== 14) begin errors++; $display("FAIL gap_done_cycle: got %0d expected 14", d); end
        tick();
    endtask

    task automatic test_len_zero;
        string s;
        int d, b, rd;
        run_xfer(16'hFFFF, 5'd0, 4'd3, 4'd1, 1'b0, s, d, b, rd);
        checks++; if (s != "") begin errors++; $display("FAIL len0_stream: got %s expected empty", s); end
        checks++; if (d !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d expected 1", d); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL len0_ready: got %b expected 1", load_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_width: got %b expected 0", done); end
    endtask

    task automatic test_len_clamp;
        string s;
        int d, b, rd;
        run_xfer(16'hA5C3, 5'd31, 4'd0, 4'd0, 1'b0, s, d, b, rd);
        checks++; if (s != "1010010111000011") begin errors++; $display("FAIL clamp_stream: got %s expected 1010010111000011", s); end
        checks++; if (d !== 17) begin errors++; $display("FAIL clamp_done_cycle: got %0d expected 17", d); end
        tick();
    endtask

    task automatic test_max_reps;
        string s, exp;
        int d, b, rd;
        exp = "";
        for (int i = 0; i < 16; i++) exp = {exp, "101"};
        run_xfer(16'h0005, 5'd3, 4'd15, 4'd0, 1'b0, s, d, b, rd);
        checks++; if (s != exp) begin errors++; $display("FAIL maxreps_stream: got %s expected %s", s, exp); end
        checks++; if (d !== 49) begin errors++; $display("FAIL maxreps_done_cycle: got %0d expected 49", d); end
        checks++; if (b !== 48) begin errors++; $display("FAIL maxreps_busy: got %0d expected 48", b); end
        tick();
    endtask

    task automatic test_ignore_busy;
        string s;
        int d, b, rd;
        run_xfer(16'h00B6, 5'd8, 4'd1, 4'd1, 1'b1, s, d, b, rd);
        checks++; if (s != "10110110-10110110") begin errors++; $display("FAIL ignore_stream: got %s expected 10110110-10110110", s); end
        checks++; if (d !== 18) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 18", d); end
        checks++; if (rd !== 0) begin errors++; $display("FAIL ignore_ready_while_busy: got %0d expected 0", rd); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got %b expected 0", dout_valid); end
    endtask

    task automatic test_back_to_back;
        string s1, s2;
        int d1, d2, b, rd;
        run_xfer(16'h0006, 5'd4, 4'd0, 4'd0, 1'b0, s1, d1, b, rd);
        checks++; if (s1 != "0110") begin errors++; $display("FAIL b2b_first_stream: got %s expected 0110", s1); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_hole: got %b expected 0", dout_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", load_ready); end
        run_xfer(16'h0009, 5'd4, 4'd0, 4'd0, 1'b0, s2, d2, b, rd);
        checks++; if (s2 != "1001") begin errors++; $display("FAIL b2b_second_stream: got %s expected 1001", s2); end
        checks++; if (d2 !== 5) begin errors++; $display("FAIL b2b_second_done: got %0d expected 5", d2); end
        tick();
    endtask

    task automatic test_reset_mid;
        string s;
        int d, b, rd, done_seen;
        load_valid = 1'b1;
        pattern = 16'h001A;
        len = 5'd5;
        reps = 4'd0;
        gap = 4'd0;
        tick();
        load_valid = 1'b0;
        tick();
        checks++; if (dout_valid !== 1'b1 || dout !== 1'b1) begin errors++; $display("FAIL rstmid_second_bit: got valid=%b dout=%b expected 1/1", dout_valid, dout); end
        #2 reset = 1'b1;
        #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", load_ready); end
        done_seen = 0;
        tick();
        if (done === 1'b1) done_seen++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1 || dout_valid === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d activity cycles expected 0", done_seen); end
        run_xfer(16'h001A, 5'd5, 4'd0, 4'd0, 1'b0, s, d, b, rd);
        checks++; if (s != "11010") begin errors++; $display("FAIL rstmid_fresh_stream: got %s expected 11010", s); end
        checks++; if (d !== 6) begin errors++; $display("FAIL rstmid_fresh_done: got %0d expected 6", d); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_len_zero();
        test_len_clamp();
        test_max_reps();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
